// File: rtl/axi_sram_pkg.sv
// Shared response codes, FSM state types and address decode helper for the AXI4-lite SRAM responder.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Unsigned wrap-around makes addresses below base land far above span, so one compare covers both sides.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] span);
    return (addr - base) < span;
  endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Word-wide storage: one asynchronous read port and one byte-masked synchronous write port, no reset.
module axi_sram_array
  import axi_sram_pkg::*;
#(
  parameter  int DEPTH = 4096,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational read sees pre-edge contents, so a same-edge write is not visible to it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4-lite memory responder with independent read/write engines, programmable latency and DECERR on misses.
module axi_sram_responder
  import axi_sram_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          RLAT  = 2,
  parameter int          WLAT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          CNT_W = 8;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  r_state_t         r_state, r_next;
  w_state_t         w_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0]      ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]       w_strb_q;
  logic             aw_got, w_got;
  logic             ar_fire, aw_fire, w_fire, r_sample, w_commit;
  logic [31:0]      rd_addr, rd_off, wr_addr, wr_off, wr_data, mem_rdata;
  logic [3:0]       wr_strb;
  logic             rd_hit, wr_hit;
  logic             unused_bits;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign awready = (w_state == W_IDLE) && !aw_got;
  assign wready  = (w_state == W_IDLE) && !w_got;
  assign bvalid  = (w_state == W_RESP);
  assign ar_fire = arvalid && arready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // With zero latency the sample/commit happens on the handshake edge, so bypass the capture registers.
  assign rd_addr = (r_state == R_IDLE) ? araddr : ar_addr_q;
  assign wr_addr = aw_got ? aw_addr_q : awaddr;
  assign wr_data = w_got ? w_data_q : wdata;
  assign wr_strb = w_got ? w_strb_q : wstrb;
  assign rd_off  = rd_addr - BASE;
  assign wr_off  = wr_addr - BASE;
  assign rd_hit  = addr_hit(rd_addr, BASE, SPAN);
  assign wr_hit  = addr_hit(wr_addr, BASE, SPAN);
  assign unused_bits = ^{rd_off[1:0], rd_off[31:IDX_W+2], wr_off[1:0], wr_off[31:IDX_W+2]};

  axi_sram_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (w_commit && wr_hit),
    .waddr (wr_off[2 +: IDX_W]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (rd_off[2 +: IDX_W]),
    .rdata (mem_rdata)
  );

  always_comb begin
    r_next   = r_state;
    r_sample = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid) begin
        if (RLAT == 0) begin
          r_next   = R_RESP;
          r_sample = 1'b1;
        end else begin
          r_next = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt == CNT_W'(1)) begin
        r_next   = R_RESP;
        r_sample = 1'b1;
      end
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      ar_addr_q <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        ar_addr_q <= araddr;
        r_cnt     <= CNT_W'(RLAT);
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_sample) begin
        rdata <= rd_hit ? mem_rdata : '0;
        rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Address and data may arrive in either order; the engine starts once both are held or arriving.
  always_comb begin
    w_next   = w_state;
    w_commit = 1'b0;
    case (w_state)
      W_IDLE: if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        if (WLAT == 0) begin
          w_next   = W_RESP;
          w_commit = 1'b1;
        end else begin
          w_next = W_WAIT;
        end
      end
      W_WAIT: if (w_cnt == CNT_W'(1)) begin
        w_next   = W_RESP;
        w_commit = 1'b1;
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_got    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_got    <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (w_state == W_IDLE && w_next == W_WAIT) begin
        w_cnt <= CNT_W'(WLAT);
      end else if (w_state == W_WAIT) begin
        w_cnt <= w_cnt - CNT_W'(1);
      end
      if (w_commit) bresp <= wr_hit ? RESP_OKAY : RESP_DECERR;
      if (w_state == W_RESP && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench: a RLAT=WLAT=2 instance for the main scenarios and a zero-latency instance for collisions.
module tb_axi_sram_responder;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int         RLAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic [31:0] z_araddr = '0, z_awaddr = '0, z_wdata = '0;
  logic        z_arvalid = 1'b0, z_rready = 1'b0, z_awvalid = 1'b0, z_wvalid = 1'b0, z_bready = 1'b0;
  logic [3:0]  z_wstrb = '0;
  logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
  logic [31:0] z_rdata;
  logic [1:0]  z_rresp, z_bresp;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [31:0] zq[$];
  int n_vec = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  axi_sram_responder #(.RLAT(2), .WLAT(2)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_responder #(.RLAT(0), .WLAT(0)) dut0 (
    .clock(clock), .reset(reset),
    .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
    .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
    .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
    .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
    .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
  );

  // order: 0 = AW and W together, 1 = W first, 2 = AW first. Starts and ends on a falling edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, fa, fw;
    int guard = 0;
    logic [1:0] exp;
    bq.push_back(exp_resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = (order != 1);
    wvalid  = (order != 2);
    while (!(aw_done && w_done) && guard < 50) begin
      fa = awvalid && awready;
      fw = wvalid && wready;
      @(negedge clock); guard++;
      if (fa) begin awvalid = 1'b0; aw_done = 1; end
      if (fw) begin wvalid = 1'b0; w_done = 1; end
      if (w_done && !aw_done && !awvalid) awvalid = 1'b1;
      if (aw_done && !w_done && !wvalid) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    guard = 0;
    while (!bvalid && guard < 50) begin @(negedge clock); guard++; end
    exp = bq.pop_front();
    n_vec++;
    if (!bvalid) begin
      n_miss++;
      $display("[TB] FAIL write_timeout addr=%h bvalid=%b required=1", addr, bvalid);
    end else if (bresp !== exp) begin
      n_miss++;
      $display("[TB] FAIL bresp addr=%h got=%b required=%b", addr, bresp, exp);
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
  endtask

  // Checks AR-to-rvalid latency, holds rready low for 'stall' cycles, then pops the scoreboard.
  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int stall);
    int guard = 0, cyc;
    logic [33:0] exp;
    rq.push_back({exp_resp, exp_data});
    araddr = addr; arvalid = 1'b1;
    while (!arready && guard < 50) begin @(negedge clock); guard++; end
    @(negedge clock);
    arvalid = 1'b0;
    cyc = 1;
    while (!rvalid && cyc < 60) begin @(negedge clock); cyc++; end
    n_vec++;
    if (!rvalid) begin
      n_miss++;
      $display("[TB] FAIL read_timeout addr=%h rvalid=%b required=1", addr, rvalid);
      void'(rq.pop_front());
      return;
    end
    if (cyc != RLAT + 1) begin
      n_miss++;
      $display("[TB] FAIL read_latency addr=%h got=%0d required=%0d", addr, cyc, RLAT + 1);
    end
    exp = rq[0];
    for (int i = 0; i < stall; i++) begin
      n_vec++;
      if (rvalid !== 1'b1 || {rresp, rdata} !== exp || arready !== 1'b0) begin
        n_miss++;
        $display("[TB] FAIL stall_hold cyc=%0d got rv=%b ar=%b r=%h required rv=1 ar=0 r=%h",
                 i, rvalid, arready, {rresp, rdata}, exp);
      end
      @(negedge clock);
    end
    exp = rq.pop_front();
    n_vec++;
    if ({rresp, rdata} !== exp) begin
      n_miss++;
      $display("[TB] FAIL rdata addr=%h got=%b/%h required=%b/%h", addr, rresp, rdata, exp[33:32], exp[31:0]);
    end
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    if (stall > 0) begin
      n_vec++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
        n_miss++;
        $display("[TB] FAIL stall_release got rv=%b ar=%b required rv=0 ar=1", rvalid, arready);
      end
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
      n_miss++;
      $display("[TB] FAIL reset_handshake got=%b required=11100", {arready, awready, wready, rvalid, bvalid});
    end
    n_vec++;
    if ({rdata, rresp, bresp} !== 36'h0) begin
      n_miss++;
      $display("[TB] FAIL reset_data got=%h required=0", {rdata, rresp, bresp});
    end
    n_vec++;
    if ({z_arready, z_awready, z_wready, z_rvalid, z_bvalid} !== 5'b11100) begin
      n_miss++;
      $display("[TB] FAIL reset_zero_lat got=%b required=11100",
               {z_arready, z_awready, z_wready, z_rvalid, z_bvalid});
    end
  endtask

  task automatic test_read_latency();
    axi_write(32'h8000_0040, 32'hDEAD_BEEF, 4'hF, 0, OKAY);
    axi_read(32'h8000_0040, 32'hDEAD_BEEF, OKAY, 0);
  endtask

  task automatic test_write_order();
    axi_write(32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 0, OKAY);
    axi_write(32'h8000_0000, 32'h1122_3344, 4'b0101, 1, OKAY);
    axi_read(32'h8000_0000, 32'hFF22_FF44, OKAY, 0);
    axi_write(32'h8000_0004, 32'hA5A5_A5A5, 4'hF, 2, OKAY);
    axi_write(32'h8000_0006, 32'h0000_0000, 4'h0, 2, OKAY);
    axi_read(32'h8000_0004, 32'hA5A5_A5A5, OKAY, 0);
  endtask

  task automatic test_decerr();
    axi_read(32'h7FFF_FFFC, 32'h0, DECERR, 0);
    axi_write(32'h8000_4000, 32'h1234_5678, 4'hF, 0, DECERR);
    axi_read(32'h8000_0000, 32'hFF22_FF44, OKAY, 0);
    axi_read(32'h8000_4000, 32'h0, DECERR, 0);
    axi_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 0, OKAY);
    axi_read(32'h8000_3FFC, 32'hCAFE_F00D, OKAY, 0);
  endtask

  task automatic test_stall();
    axi_read(32'h8000_0040, 32'hDEAD_BEEF, OKAY, 5);
    axi_read(32'h8000_0004, 32'hA5A5_A5A5, OKAY, 0);
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    araddr = 32'h8000_0040; arvalid = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    reset = 1'b0;
    #2;
    n_vec++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_assert got rv=%b ar=%b required rv=0 ar=1", rvalid, arready);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (rvalid !== 1'b0 || arready !== 1'b1) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_quiet got rv=%b ar=%b required rv=0 ar=1", rvalid, arready);
    end
    axi_read(32'h8000_0040, 32'hDEAD_BEEF, OKAY, 0);
  endtask

  // Zero-latency instance: a commit and a read sample on the same edge must return the old word.
  task automatic test_collision();
    logic [31:0] exp;
    z_awaddr = 32'h8000_0014; z_wdata = 32'h1; z_wstrb = 4'hF;
    z_awvalid = 1'b1; z_wvalid = 1'b1;
    @(negedge clock);
    z_awvalid = 1'b0; z_wvalid = 1'b0;
    n_vec++;
    if (z_bvalid !== 1'b1 || z_bresp !== OKAY) begin
      n_miss++;
      $display("[TB] FAIL zlat_write got bv=%b resp=%b required bv=1 resp=00", z_bvalid, z_bresp);
    end
    z_bready = 1'b1;
    @(negedge clock);
    z_bready = 1'b0;

    zq.push_back(32'h1);
    z_wdata = 32'h2;
    z_awvalid = 1'b1; z_wvalid = 1'b1;
    z_araddr = 32'h8000_0014; z_arvalid = 1'b1;
    @(negedge clock);
    z_awvalid = 1'b0; z_wvalid = 1'b0; z_arvalid = 1'b0;
    exp = zq.pop_front();
    n_vec++;
    if (z_rvalid !== 1'b1 || z_rdata !== exp || z_bvalid !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL collision_old got rv=%b bv=%b r=%h required rv=1 bv=1 r=%h",
               z_rvalid, z_bvalid, z_rdata, exp);
    end
    z_rready = 1'b1; z_bready = 1'b1;
    @(negedge clock);
    z_rready = 1'b0; z_bready = 1'b0;

    zq.push_back(32'h2);
    z_arvalid = 1'b1;
    @(negedge clock);
    z_arvalid = 1'b0;
    exp = zq.pop_front();
    n_vec++;
    if (z_rvalid !== 1'b1 || z_rdata !== exp || z_rresp !== OKAY) begin
      n_miss++;
      $display("[TB] FAIL collision_new got rv=%b r=%h required rv=1 r=%h", z_rvalid, z_rdata, exp);
    end
    z_rready = 1'b1;
    @(negedge clock);
    z_rready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_read_latency();
    test_write_order();
    test_decerr();
    test_stall();
    test_reset_mid();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
